// File: rtl/bmem_line_adapter.sv
// bmem_line_adapter
//   Bridges the L2 cache line port to the off-chip burst memory pins.
//   Reads collect BURST_LEN beats into one line. Writes split one line into
//   BURST_LEN back-to-back beats, then wait for the memory acknowledge.
//
// Ports
//   clk, rst            clock; asynchronous active-low reset
//   line_addr/read/write/wdata   line request from the cache (sampled in IDLE)
//   line_rdata          assembled read line, held until the next read completes
//   line_resp           one-cycle completion pulse
//   bmem_address        line-aligned burst address
//   bmem_read/write     burst read / write request
//   bmem_wdata          write beat; bmem_rdata read beat; bmem_resp memory response
//   proto_err           sticky flag for unexpected bmem_resp
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for a line request
// RD_WAIT | read issued, waiting for the first beat
// RD_BEAT | collecting beats 1..BURST_LEN-1 (bmem_resp low = stall)
// WR_BEAT | driving write beats back-to-back, one per cycle
// WR_WAIT | write burst sent, waiting for the memory acknowledge
// DONE    | line_resp pulse, then back to IDLE
module bmem_line_adapter #(
  parameter int LOG2_LINEBITS = 10,
  parameter int BEAT_WIDTH    = 64,
  parameter int ADDR_WIDTH    = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [ADDR_WIDTH-1:0]         line_addr,
  input  logic                          line_read,
  input  logic                          line_write,
  input  logic [2**LOG2_LINEBITS-1:0]   line_wdata,
  output logic [2**LOG2_LINEBITS-1:0]   line_rdata,
  output logic                          line_resp,
  output logic [ADDR_WIDTH-1:0]         bmem_address,
  output logic                          bmem_read,
  output logic                          bmem_write,
  output logic [BEAT_WIDTH-1:0]         bmem_wdata,
  input  logic [BEAT_WIDTH-1:0]         bmem_rdata,
  input  logic                          bmem_resp,
  output logic                          proto_err
);

  localparam int LINE_BITS = 2**LOG2_LINEBITS;
  localparam int BURST_LEN = LINE_BITS / BEAT_WIDTH;
  localparam int CNT_W     = LOG2_LINEBITS - 6;
  localparam int OFF_BITS  = LOG2_LINEBITS - 3;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_WAIT = 3'd1,
    RD_BEAT = 3'd2,
    WR_BEAT = 3'd3,
    WR_WAIT = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  // Shared buffer: holds the write line, or the line being assembled on a read.
  // line_rdata is a separate copy so it stays stable during the next read.
  logic [LINE_BITS-1:0]    buf_q, buf_d;
  logic [LINE_BITS-1:0]    rdata_q, rdata_d;
  logic                    perr_q, perr_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      buf_q   <= '0;
      rdata_q <= '0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      buf_q   <= buf_d;
      rdata_q <= rdata_d;
      perr_q  <= perr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    buf_d      = buf_q;
    rdata_d    = rdata_q;
    perr_d     = perr_q;
    bmem_read  = 1'b0;
    bmem_write = 1'b0;
    bmem_wdata = '0;
    line_resp  = 1'b0;

    case (state_q)
      IDLE: begin
        // A response here is either spurious or a beat beyond BURST_LEN.
        if (bmem_resp) perr_d = 1'b1;
        if (line_write) begin
          addr_d  = {line_addr[ADDR_WIDTH-1:OFF_BITS], {OFF_BITS{1'b0}}};
          buf_d   = line_wdata;
          cnt_d   = '0;
          state_d = WR_BEAT;
        end else if (line_read) begin
          addr_d  = {line_addr[ADDR_WIDTH-1:OFF_BITS], {OFF_BITS{1'b0}}};
          cnt_d   = '0;
          state_d = RD_WAIT;
        end
      end

      RD_WAIT: begin
        bmem_read = 1'b1;
        if (bmem_resp) begin
          buf_d[BEAT_WIDTH-1:0] = bmem_rdata;
          cnt_d   = CNT_W'(1);
          state_d = RD_BEAT;
        end
      end

      RD_BEAT: begin
        bmem_read = 1'b1;
        if (bmem_resp) begin
          buf_d[int'(cnt_q)*BEAT_WIDTH +: BEAT_WIDTH] = bmem_rdata;
          if (cnt_q == LAST_BEAT) begin
            rdata_d = buf_d;
            cnt_d   = '0;
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      WR_BEAT: begin
        if (bmem_resp) perr_d = 1'b1;
        bmem_write = 1'b1;
        bmem_wdata = buf_q[int'(cnt_q)*BEAT_WIDTH +: BEAT_WIDTH];
        if (cnt_q == LAST_BEAT) begin
          cnt_d   = '0;
          state_d = WR_WAIT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      WR_WAIT: begin
        if (bmem_resp) state_d = DONE;
      end

      DONE: begin
        // Extra read beats after the last one land here or in IDLE.
        if (bmem_resp) perr_d = 1'b1;
        line_resp = 1'b1;
        cnt_d     = '0;
        state_d   = IDLE;
      end

      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  assign line_rdata   = rdata_q;
  assign bmem_address = addr_q;
  assign proto_err    = perr_q;

endmodule

// File: tb/tb_bmem_line_adapter.sv
module tb_bmem_line_adapter;
  localparam int LB = 1024;
  localparam int BW = 64;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [AW-1:0] line_addr = '0;
  logic          line_read = 1'b0;
  logic          line_write = 1'b0;
  logic [LB-1:0] line_wdata = '0;
  logic [LB-1:0] line_rdata;
  logic          line_resp;
  logic [AW-1:0] bmem_address;
  logic          bmem_read;
  logic          bmem_write;
  logic [BW-1:0] bmem_wdata;
  logic [BW-1:0] bmem_rdata = '0;
  logic          bmem_resp = 1'b0;
  logic          proto_err;

  bmem_line_adapter #(.LOG2_LINEBITS(10), .BEAT_WIDTH(64), .ADDR_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .line_addr(line_addr), .line_read(line_read), .line_write(line_write),
    .line_wdata(line_wdata), .line_rdata(line_rdata), .line_resp(line_resp),
    .bmem_address(bmem_address), .bmem_read(bmem_read), .bmem_write(bmem_write),
    .bmem_wdata(bmem_wdata), .bmem_rdata(bmem_rdata), .bmem_resp(bmem_resp),
    .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int resp_cnt = 0;
  int resp_cyc = 0;
  int rd_hi = 0;
  int wr_hi = 0;
  logic [LB-1:0] exp_q[$];
  logic [LB-1:0] last_line = '0;
  logic [LB-1:0] mon_exp;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bmem_read === 1'b1) rd_hi++;
    if (bmem_write === 1'b1) wr_hi++;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_line(input string name, input logic [LB-1:0] act, input logic [LB-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      for (int k = 0; k < LB / BW; k++) begin
        if (act[k*BW +: BW] !== exp[k*BW +: BW]) begin
          $display("FAIL %s beat %0d actual=%h required=%h (t=%0t)", name, k,
                   act[k*BW +: BW], exp[k*BW +: BW], $time);
          break;
        end
      end
    end
  endtask

  function automatic logic [LB-1:0] mk_line(input logic [31:0] hi, input logic [31:0] lo_base);
    logic [LB-1:0] l;
    l = '0;
    for (int k = 0; k < LB / BW; k++) l[k*BW +: BW] = {hi, lo_base + 32'(k)};
    return l;
  endfunction

  // Scoreboard monitor: every line_resp pops one expected line.
  always @(negedge clk) begin
    if (rst === 1'b1 && line_resp === 1'b1) begin
      resp_cnt++;
      resp_cyc = cyc;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_line_resp actual=1 required=0 (t=%0t)", $time);
      end else begin
        mon_exp = exp_q.pop_front();
        chk_line("sb_line_rdata", line_rdata, mon_exp);
      end
    end
  end

  task automatic wait_resp(input int prev, input int max_cyc);
    int n;
    n = 0;
    while (resp_cnt == prev && n < max_cyc) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (resp_cnt == prev) begin
      checks++;
      failures++;
      $display("FAIL resp_timeout actual=none required=line_resp within %0d cycles", max_cyc);
    end
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [31:0] base,
                         input int stall_after, input int nstall, input int abort_after);
    logic [LB-1:0] ln;
    logic [31:0]   aligned;
    int t0, prev;
    bit aborted;
    ln = mk_line(32'h0, base);
    aligned = addr & ~32'h7F;
    aborted = 0;
    @(posedge clk); #1;
    line_addr = addr;
    line_read = 1'b1;
    t0 = cyc;
    prev = resp_cnt;
    rd_hi = 0;
    if (abort_after < 0) begin
      exp_q.push_back(ln);
      last_line = ln;
    end
    @(posedge clk); #1;
    line_read = 1'b0;
    // memory answers one cycle after it sees bmem_read
    @(posedge clk); #1;
    for (int k = 0; k < LB / BW && !aborted; k++) begin
      chk("rd_bmem_address", 64'(bmem_address), 64'(aligned));
      chk("rd_bmem_read", 64'(bmem_read), 64'd1);
      bmem_resp = 1'b1;
      bmem_rdata = {32'h0, base + 32'(k)};
      @(posedge clk); #1;
      bmem_resp = 1'b0;
      if (k == abort_after) begin
        rst = 1'b0;
        #1;
        chk("abort_bmem_read", 64'(bmem_read), 64'd0);
        chk("abort_line_resp", 64'(line_resp), 64'd0);
        chk("abort_proto_err", 64'(proto_err), 64'd0);
        chk("abort_line_rdata_lo", line_rdata[63:0], 64'd0);
        last_line = '0;
        @(posedge clk); #3;
        rst = 1'b1;
        aborted = 1;
      end
      if (k == stall_after) repeat (nstall) begin
        @(posedge clk); #1;
      end
    end
    bmem_rdata = '0;
    if (!aborted) begin
      wait_resp(prev, 40);
      chk("rd_latency", 64'(resp_cyc - t0), 64'(18 + nstall));
      chk("rd_bmem_read_cycles", 64'(rd_hi), 64'(17 + nstall));
    end
  endtask

  task automatic do_write(input logic [31:0] addr, input bit also_read);
    logic [LB-1:0] ln;
    logic [31:0]   aligned;
    int t0, prev;
    ln = mk_line(32'hA5A5A5A5, 32'h0);
    aligned = addr & ~32'h7F;
    @(posedge clk); #1;
    line_addr = addr;
    line_wdata = ln;
    line_write = 1'b1;
    line_read = also_read;
    t0 = cyc;
    prev = resp_cnt;
    wr_hi = 0;
    rd_hi = 0;
    exp_q.push_back(last_line);
    @(posedge clk); #1;
    line_write = 1'b0;
    line_read = 1'b0;
    for (int k = 0; k < LB / BW; k++) begin
      chk("wr_bmem_write", 64'(bmem_write), 64'd1);
      chk("wr_bmem_read", 64'(bmem_read), 64'd0);
      chk("wr_bmem_wdata", bmem_wdata, {32'hA5A5A5A5, 32'(k)});
      chk("wr_bmem_address", 64'(bmem_address), 64'(aligned));
      @(posedge clk); #1;
    end
    chk("wr_write_dropped", 64'(bmem_write), 64'd0);
    @(posedge clk); #1;
    bmem_resp = 1'b1;
    @(posedge clk); #1;
    bmem_resp = 1'b0;
    wait_resp(prev, 20);
    chk("wr_latency", 64'(resp_cyc - t0), 64'd19);
    chk("wr_bmem_write_cycles", 64'(wr_hi), 64'd16);
    chk("wr_no_read_cycles", 64'(rd_hi), 64'd0);
  endtask

  initial begin
    #2;
    chk("rst_line_resp", 64'(line_resp), 64'd0);
    chk("rst_bmem_read", 64'(bmem_read), 64'd0);
    chk("rst_bmem_write", 64'(bmem_write), 64'd0);
    chk("rst_bmem_address", 64'(bmem_address), 64'd0);
    chk("rst_bmem_wdata", bmem_wdata, 64'd0);
    chk("rst_proto_err", 64'(proto_err), 64'd0);
    chk_line("rst_line_rdata", line_rdata, '0);
    #20;
    rst = 1'b1;

    do_read(32'h40000044, 32'h11110000, -1, 0, -1);
    chk("rd1_beat0", line_rdata[63:0], 64'h0000_0000_1111_0000);
    chk("rd1_beat15", line_rdata[1023:960], 64'h0000_0000_1111_000F);
    chk("rd1_proto_err", 64'(proto_err), 64'd0);

    do_read(32'h40000044, 32'h11110000, 5, 3, -1);
    chk("rd_stall_proto_err", 64'(proto_err), 64'd0);

    do_write(32'h40000080, 1'b0);
    do_write(32'h00000100, 1'b1);
    do_read(32'h00000100, 32'h22220000, -1, 0, -1);

    @(posedge clk); #1;
    bmem_resp = 1'b1;
    @(posedge clk); #1;
    bmem_resp = 1'b0;
    chk("idle_resp_proto_err", 64'(proto_err), 64'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("proto_err_sticky", 64'(proto_err), 64'd1);
    do_read(32'h00002010, 32'h33330000, -1, 0, -1);
    chk("proto_err_after_read", 64'(proto_err), 64'd1);

    do_read(32'h00005000, 32'h44440000, -1, 0, 7);
    repeat (5) @(posedge clk);
    #1;
    chk("post_abort_proto_err", 64'(proto_err), 64'd0);
    chk("post_abort_bmem_read", 64'(bmem_read), 64'd0);
    do_read(32'h00005000, 32'h55550000, -1, 0, -1);
    chk("reread_beat7", line_rdata[7*64 +: 64], 64'h0000_0000_5555_0007);

    repeat (3) @(posedge clk);
    #1;
    chk("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
